hc595_driver: RTL and testbench
===============================

# hc595_driver

Sequencing controller for the 74HC595 shift/storage register pair on the board. Accepts a parallel word over a valid/ready handshake and generates `si`, `sck`, `rck`, `sclr_n` and `g_n` for one chip or a daisy-chain of chips. It sits between the system logic (LED and segment drivers) and the 595 pins. It owns all 595 timing, so upstream logic never toggles the pins directly.

## Interface
- `N_CHIPS`, default 1: number of cascaded 595s. Word width W = 8*N_CHIPS.
- `DIV`, default 4: system clocks per half period of `sck`/`rck`/`sclr_n` pulses. Must be ≥1.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  write request.
- `req_data`  in  W  word to display. Bit W-1 is shifted first and ends on the last chip's Q7.
- `req_ready`  out  1  high only in IDLE.
- `clr_req`  in  1  clear request. Sampled only in IDLE.
- `oe_en`  in  1  output enable request.
- `done`  out  1  one-cycle pulse when a write or clear finishes.
- `si`  out  1  serial data to the 595.
- `sck`  out  1  shift clock to the 595.
- `rck`  out  1  storage clock to the 595.
- `sclr_n`  out  1  shift register clear, active-low.
- `g_n`  out  1  output enable, active-low.

## Operation
- All outputs are registered.
- Reset values: `si`=0, `sck`=0, `rck`=0, `sclr_n`=1, `g_n`=1, `done`=0, `req_ready`=1. State is IDLE, counters are 0.
- States: IDLE, CLR, SH_LO, SH_HI, LATCH.
- IDLE:
  - If `clr_req`=1, go to CLR. `clr_req` wins when `clr_req` and `req_valid` are both high; the write is not accepted and `req_ready` drops.
  - Else if `req_valid`=1, capture `req_data` into the internal shift register, clear the bit count and go to SH_LO.
- SH_LO, DIV cycles: `sck`=0, `si`=current MSB of the internal shift register.
- SH_HI, DIV cycles: `sck`=1 and `si` is held.
  - On exit, shift the internal register left by 1 and increment the bit count.
  - If bit count = W, go to LATCH. Otherwise go back to SH_LO.
- CLR, DIV cycles: `sclr_n`=0, then go to LATCH.
- LATCH, DIV cycles: `rck`=1, `sck`=0, `sclr_n`=1. On exit, `rck` returns to 0, `done` pulses for 1 cycle and the state returns to IDLE.
- `g_n` = registered ~`oe_en`, one cycle of latency, except where `HC595_BLANK_EN` overrides it.
- Changes to `req_data` after acceptance have no effect.
- `req_valid` that is not accepted (i.e. outside IDLE) is not queued. The requester must hold it until `req_ready`=1.
- Reset mid-transaction aborts immediately and forces the reset values. The 595 storage register keeps its old contents because no `rck` pulse is issued.
- Counters: the DIV counter is $clog2(DIV+1) bits and the bit counter is $clog2(W+1) bits. Neither counter wraps mid-phase.

## Timing
- Write latency, from the accept edge to the `done` pulse: 2·DIV·W + DIV cycles. For W=8 and DIV=4 this is 68.
- `req_ready` returns to 1 in the same cycle as `done`.
- Back-to-back writes: the next request can be accepted in the cycle after `done`. This gives one IDLE cycle per transaction.
- Clear latency, from the accept edge to `done`: 2·DIV cycles.
- Serial timing:
  - `si` is stable for DIV cycles before each `sck` rising edge and for DIV cycles after it.
  - The first `sck` rising edge occurs DIV cycles after acceptance.
  - `rck` rises DIV cycles after the last `sck` rising edge, at the same edge where `sck` falls.
- `sck` period = 2·DIV cycles, with a 50% duty cycle.
- `sclr_n` low-pulse width = DIV cycles.
- `rck` high-pulse width = DIV cycles.

## Configuration
- Macro `HC595_BLANK_EN`:
  - Defined: `g_n` is forced to 1 in SH_LO, SH_HI, CLR and LATCH, so the display blanks during updates. `g_n` returns to ~`oe_en` in the cycle after the return to IDLE.
  - Not defined: `g_n` follows ~`oe_en` in every state. This is glitch-free because the 595 storage register holds its value during shifting.

## Test plan
- Reset, N_CHIPS=1, DIV=4: hold `rst`=1 → all outputs at their reset values. Release `rst`, write 8'hA5 → 8 `sck` rising edges with `si` sequence 1,0,1,0,0,1,0,1; one `rck` pulse 4 cycles wide; `done` exactly 68 cycles after accept; 595 model Q=8'hA5.
- N_CHIPS=2, DIV=1: write 16'h1234 → 16 `sck` edges; chip1 Q=8'h12, chip0 Q=8'h34; `done` at cycle 33.
- `clr_req` and `req_valid` high in the same cycle (DIV=4) → `sclr_n` low for 4 cycles, then an `rck` pulse, Q=8'h00, `done` at cycle 8. The write is not accepted and is accepted in the cycle after `done` if still held.
- Assert `rst` during the 5th SH_HI of a write → all outputs return to reset values asynchronously. 595 Q keeps its previous value. A fresh write of 8'hFF then completes normally.
- Hold `req_valid`=1 with three different words, back-to-back → `req_ready` low in every non-IDLE cycle. Each word is latched in order, with exactly one IDLE cycle between `done` and the next accept.
- With `HC595_BLANK_EN` defined and `oe_en`=1: `g_n`=1 for the whole transaction and `g_n`=0 one cycle after `done`. With the macro undefined: `g_n` stays 0 throughout.

Source files
------------

// File: rtl/hc595_driver.sv
// hc595_driver: sequences si/sck/rck/sclr_n/g_n for one or more cascaded 74HC595s.
// A word accepted over req_valid/req_ready is shifted MSB first. A clear request pulses
// sclr_n and then latches the empty shift register into the storage register.
// Optional macro HC595_BLANK_EN: hold g_n high while an update is in progress.
module hc595_driver #(
  parameter int unsigned N_CHIPS = 1,
  parameter int unsigned DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [8*N_CHIPS-1:0]   req_data,
  output logic                   req_ready,
  input  logic                   clr_req,
  input  logic                   oe_en,
  output logic                   done,
  output logic                   si,
  output logic                   sck,
  output logic                   rck,
  output logic                   sclr_n,
  output logic                   g_n
);

  localparam int unsigned Width = 8 * N_CHIPS;
  localparam int unsigned DivW  = $clog2(DIV + 1);
  localparam int unsigned BitW  = $clog2(Width + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitsAll = BitW'(Width);

  typedef enum logic [2:0] {StIdle, StClr, StShLo, StShHi, StLatch} state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   sh_q, sh_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic               phase_end;
  logic               done_d, si_d, sck_d, rck_d, sclr_n_d, g_n_d, req_ready_d;

  assign phase_end = (div_q == DivLast);

  // Next-state: phase sequencing, shift register and counters.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    div_d   = div_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d = '0;
        // A clear outranks a write presented in the same cycle.
        if (clr_req) begin
          state_d = StClr;
        end else if (req_valid) begin
          sh_d    = req_data;
          bit_d   = '0;
          state_d = StShLo;
        end
      end
      StClr: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = StLatch;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShLo: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = StShHi;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShHi: begin
        if (phase_end) begin
          div_d   = '0;
          sh_d    = {sh_q[Width-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_d == BitsAll) ? StLatch : StShLo;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLatch: begin
        if (phase_end) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are decoded from the upcoming state so every output is a plain register.
  always_comb begin
    si_d        = si;
    sck_d       = 1'b0;
    rck_d       = 1'b0;
    sclr_n_d    = 1'b1;
    req_ready_d = (state_d == StIdle);
    unique case (state_d)
      StShLo:  si_d     = sh_d[Width-1];
      StShHi:  sck_d    = 1'b1;
      StClr:   sclr_n_d = 1'b0;
      StLatch: rck_d    = 1'b1;
      default: ;
    endcase
`ifdef HC595_BLANK_EN
    // Blank from the accept edge until one cycle after the return to idle.
    g_n_d = ((state_q != StIdle) || (state_d != StIdle)) ? 1'b1 : ~oe_en;
`else
    g_n_d = ~oe_en;
`endif
  end

  // State, datapath and output registers; reset aborts without an rck pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      done      <= 1'b0;
      si        <= 1'b0;
      sck       <= 1'b0;
      rck       <= 1'b0;
      sclr_n    <= 1'b1;
      g_n       <= 1'b1;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      done      <= done_d;
      si        <= si_d;
      sck       <= sck_d;
      rck       <= rck_d;
      sclr_n    <= sclr_n_d;
      g_n       <= g_n_d;
      req_ready <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: one instance with N_CHIPS=1/DIV=4 and one with N_CHIPS=2/DIV=1,
// each feeding a behavioural 595 chain. Expected storage contents go into a queue on accept
// and are compared against the model when done pulses.
module tb_hc595_driver;

`ifdef HC595_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: one chip, DIV=4
  logic       valid_a, clr_a, oe_a;
  logic [7:0] data_a;
  logic       ready_a, done_a, si_a, sck_a, rck_a, sclr_n_a, g_n_a;

  hc595_driver #(.N_CHIPS(1), .DIV(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_data(data_a), .req_ready(ready_a),
    .clr_req(clr_a), .oe_en(oe_a), .done(done_a), .si(si_a), .sck(sck_a), .rck(rck_a),
    .sclr_n(sclr_n_a), .g_n(g_n_a)
  );

  // Instance B: two chips, DIV=1
  logic        valid_b, clr_b, oe_b;
  logic [15:0] data_b;
  logic        ready_b, done_b, si_b, sck_b, rck_b, sclr_n_b, g_n_b;

  hc595_driver #(.N_CHIPS(2), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_data(data_b), .req_ready(ready_b),
    .clr_req(clr_b), .oe_en(oe_b), .done(done_b), .si(si_b), .sck(sck_b), .rck(rck_b),
    .sclr_n(sclr_n_b), .g_n(g_n_b)
  );

  // 595 chain models: shift on sck rise, async clear on sclr_n low, latch on rck rise.
  logic [7:0]  sr_a = '0, q_a = '0, si_bits_a = '0;
  int          sck_cnt_a = 0;
  logic [15:0] sr_b = '0, q_b = '0;
  int          sck_cnt_b = 0;

  always @(posedge sck_a or negedge sclr_n_a) begin
    if (!sclr_n_a) sr_a <= '0;
    else begin
      sr_a <= {sr_a[6:0], si_a};
      si_bits_a = {si_bits_a[6:0], si_a};
      sck_cnt_a++;
    end
  end
  always @(posedge rck_a) q_a <= sr_a;

  always @(posedge sck_b or negedge sclr_n_b) begin
    if (!sclr_n_b) sr_b <= '0;
    else begin
      sr_b <= {sr_b[14:0], si_b};
      sck_cnt_b++;
    end
  end
  always @(posedge rck_b) q_b <= sr_b;

  // Pulse widths of rck high and sclr_n low, in clock cycles.
  time t_rck = 0, t_sclr = 0;
  int  rck_w_a = 0, sclr_w_a = 0;
  always @(posedge rck_a) t_rck = $time;
  always @(negedge rck_a) rck_w_a = int'(($time - t_rck) / 10);
  always @(negedge sclr_n_a) t_sclr = $time;
  always @(posedge sclr_n_a) sclr_w_a = int'(($time - t_sclr) / 10);

  // g_n watch with oe_en=1: high throughout a transaction only when blanking is built in.
  bit gn_mon = 1'b0;
  int gn_bad = 0;
  always @(negedge clk) begin
    if (gn_mon && (g_n_a !== ((Blank && (!ready_a || done_a)) ? 1'b1 : 1'b0))) gn_bad++;
  end

  logic [7:0]  exp_a[$];
  logic [15:0] exp_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after an idle edge; the next edge accepts d.
  task automatic accept_a(input logic [7:0] d, input bit push);
    check("a_idle_ready", ready_a, 1'b1);
    valid_a = 1'b1;
    data_a  = d;
    @(posedge clk); #1;
    check("a_busy_after_accept", ready_a, 1'b0);
    if (push) exp_a.push_back(d);
    valid_a = 1'b0;
    data_a  = ~d;  // late change must not reach the chip
  endtask

  // Counts cycles from the accept edge to done and pops the scoreboard at done.
  task automatic wait_done_a(output int lat, output int busy_bad);
    lat = 0;
    busy_bad = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!done_a && ready_a) busy_bad++;
    end while (!done_a && lat < 2000);
    if (!done_a) check("a_done_timeout", 32'd0, 32'd1);
    else if (exp_a.size() == 0) check("a_sb_underflow", 32'd0, 32'd1);
    else check("a_sb_q", q_a, exp_a.pop_front());
  endtask

  task automatic wait_done_b(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_b && lat < 2000);
    if (!done_b) check("b_done_timeout", 32'd0, 32'd1);
    else if (exp_b.size() == 0) check("b_sb_underflow", 32'd0, 32'd1);
    else check("b_sb_q", q_b, exp_b.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat, bb, s0, acc_cyc, done_cyc;
    logic [7:0] words [3];
    words[0] = 8'h81; words[1] = 8'h7E; words[2] = 8'hC3;
    done_cyc = 0;

    rst = 1'b1;
    valid_a = 1'b0; data_a = '0; clr_a = 1'b0; oe_a = 1'b1;
    valid_b = 1'b0; data_b = '0; clr_b = 1'b0; oe_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_outs", {si_a, sck_a, rck_a, sclr_n_a, g_n_a, done_a, ready_a}, 7'b0001101);
    check("b_reset_outs", {si_b, sck_b, rck_b, sclr_n_b, g_n_b, done_b, ready_b}, 7'b0001101);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_gn_idle", g_n_a, 1'b0);
    gn_mon = 1'b1;

    // Single write of A5
    s0 = sck_cnt_a;
    accept_a(8'hA5, 1'b1);
    wait_done_a(lat, bb);
    check("a5_latency", lat, 68);
    check("a5_ready_low_busy", bb, 0);
    check("a5_sck_edges", sck_cnt_a - s0, 8);
    check("a5_si_seq", si_bits_a, 8'hA5);
    check("a5_rck_width", rck_w_a, 4);
    @(posedge clk); #1;
    check("a5_gn_after_done", g_n_a, 1'b0);

    // Clear and write together: clear wins, held write follows right after done
    valid_a = 1'b1; data_a = 8'h3C; clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    check("clr_write_refused", ready_a, 1'b0);
    exp_a.push_back(8'h00);
    wait_done_a(lat, bb);
    check("clr_latency", lat, 8);
    check("clr_sclr_width", sclr_w_a, 4);
    check("clr_rck_width", rck_w_a, 4);
    @(posedge clk); #1;
    check("held_write_accepted", ready_a, 1'b0);
    exp_a.push_back(8'h3C);
    valid_a = 1'b0; data_a = 8'h00;
    wait_done_a(lat, bb);
    check("held_write_latency", lat, 68);

    // Reset during the 5th SH_HI of a write: storage keeps 3C
    gn_mon = 1'b0;
    @(posedge clk); #1;
    accept_a(8'h5A, 1'b0);
    repeat (36) @(posedge clk);
    #2;
    check("midwrite_sck_high", sck_a, 1'b1);
    rst = 1'b1;
    #1;
    check("midwrite_reset_outs", {si_a, sck_a, rck_a, sclr_n_a, g_n_a, done_a, ready_a},
          7'b0001101);
    check("midwrite_q_kept", q_a, 8'h3C);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    accept_a(8'hFF, 1'b1);
    wait_done_a(lat, bb);
    check("ff_latency", lat, 68);

    // Back-to-back words with req_valid held
    @(posedge clk); #1;
    gn_mon = 1'b1;
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_a = words[i];
      @(posedge clk); #1;
      acc_cyc = cyc;
      check("b2b_accept", ready_a, 1'b0);
      if (i > 0) check("b2b_idle_gap", acc_cyc - done_cyc, 1);
      exp_a.push_back(words[i]);
      wait_done_a(lat, bb);
      done_cyc = cyc;
      check("b2b_ready_low_busy", bb, 0);
    end
    valid_a = 1'b0;
    @(posedge clk); #1;
    gn_mon = 1'b0;
    check("gn_behaviour", gn_bad, 0);

    // Two chips, DIV=1
    s0 = sck_cnt_b;
    check("b_idle_ready", ready_b, 1'b1);
    valid_b = 1'b1; data_b = 16'h1234;
    @(posedge clk); #1;
    exp_b.push_back(16'h1234);
    valid_b = 1'b0; data_b = 16'hFFFF;
    wait_done_b(lat);
    check("b_latency", lat, 33);
    check("b_sck_edges", sck_cnt_b - s0, 16);
    check("b_chip1_q", q_b[15:8], 8'h12);
    check("b_chip0_q", q_b[7:0], 8'h34);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
